// File: rtl/sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sr_flag_arbiter
// Purpose  : Shares one bank of NFLAG SR-style status flags between NREQ
//            requesters. A round-robin arbiter picks one requester per ARB
//            cycle; the following APPLY cycle writes the captured {S,R}
//            command into the flag bank and pulses gnt to the winner.
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous active-high reset
//            req      - [NREQ]        per-requester request
//            req_sr   - [2*NREQ]      per-requester {S,R}, bits [2i+1:2i]
//            req_idx  - [IDX_W*NREQ]  per-requester flag index
//            gnt      - [NREQ]        one-hot one-cycle grant (APPLY cycle)
//            err      - illegal command ({1,1} or idx>=NFLAG), with gnt
//            Q / Qbar - [NFLAG]       flag bank and its inverse
//            busy     - high while in APPLY
// Options  : SR_FLAG_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins)
//            instead of round-robin; no rotating pointer is built.
// Revision : 1.0 - initial release
// ============================================================================
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_sr,
  input  logic [IDX_W*NREQ-1:0]   req_idx,
  output logic [NREQ-1:0]         gnt,
  output logic                    err,
  output logic [NFLAG-1:0]        Q,
  output logic [NFLAG-1:0]        Qbar,
  output logic                    busy
);

  localparam int              WIN_W   = $clog2(NREQ);
  localparam logic [IDX_W:0]  NFLAG_C = (IDX_W+1)'(NFLAG);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  state_t             state_q;
  logic [NFLAG-1:0]   flags_q;
  logic [1:0]         sr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NREQ-1:0]    gnt_q;
  logic               err_q;
  logic               busy_q;

  logic [WIN_W-1:0]   win_d;
  logic [WIN_W-1:0]   cand;
  logic               found_d;
  logic [1:0]         sr_d;
  logic [IDX_W-1:0]   idx_d;
  logic               illegal_d;
  logic [NREQ-1:0]    gnt_d;

`ifndef SR_FLAG_ARB_FIXED_PRIO_EN
  localparam logic [WIN_W:0] NREQ_C = (WIN_W+1)'(NREQ);
  logic [WIN_W-1:0]   rr_ptr_q;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W:0]     sum;
`endif

  // Winner search: first requester with req high, scanning upward from the
  // start point (rr_ptr, or 0 for fixed priority) and wrapping at NREQ.
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    cand    = '0;
`ifndef SR_FLAG_ARB_FIXED_PRIO_EN
    sum     = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
`ifdef SR_FLAG_ARB_FIXED_PRIO_EN
      cand = WIN_W'(k);
`else
      sum = {1'b0, rr_ptr_q} + (WIN_W+1)'(k);
      if (sum >= NREQ_C) sum = sum - NREQ_C;
      cand = sum[WIN_W-1:0];
`endif
      if (!found_d && req[cand]) begin
        found_d = 1'b1;
        win_d   = cand;
      end
    end
  end

  always_comb begin
    sr_d      = req_sr[2*int'(win_d) +: 2];
    idx_d     = req_idx[IDX_W*int'(win_d) +: IDX_W];
    // Legality is decided at capture so err can be registered alongside gnt.
    illegal_d = (sr_d == 2'b11) || ({1'b0, idx_d} >= NFLAG_C);
    gnt_d     = '0;
    gnt_d[win_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ARB;
      flags_q  <= '0;
      sr_q     <= '0;
      idx_q    <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifndef SR_FLAG_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
      win_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_ARB: begin
          gnt_q  <= '0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          if (|req) begin
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            // gnt/err/busy are registered so they appear during APPLY.
            gnt_q   <= gnt_d;
            err_q   <= illegal_d;
            busy_q  <= 1'b1;
            state_q <= ST_APPLY;
`ifndef SR_FLAG_ARB_FIXED_PRIO_EN
            win_q   <= win_d;
`endif
          end
        end
        ST_APPLY: begin
          // err_q covers both {1,1} and an out-of-range index: no write.
          if (!err_q) begin
            case (sr_q)
              2'b10:   flags_q[idx_q] <= 1'b1;
              2'b01:   flags_q[idx_q] <= 1'b0;
              default: ;
            endcase
          end
`ifndef SR_FLAG_ARB_FIXED_PRIO_EN
          rr_ptr_q <= (win_q == WIN_W'(NREQ-1)) ? '0 : win_q + WIN_W'(1);
`endif
          gnt_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_ARB;
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign Q    = flags_q;
  assign Qbar = ~flags_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_flag_arbiter
// Purpose  : Self-checking bench for sr_flag_arbiter. Two instances share
//            the stimulus: one with NFLAG=8 and one with NFLAG=6, so the
//            out-of-range index case is exercised on the narrow bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_flag_arbiter;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  req_sr = '0;
  logic [11:0] req_idx = '0;
  logic [3:0]  gnt, gnt6;
  logic        err, err6, busy, busy6;
  logic [7:0]  Q, Qbar;
  logic [5:0]  Q6, Qbar6;

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: pending command plus the two flag banks.
  bit         m_apply;
  int         m_win, m_ptr, m_idx;
  logic [1:0] m_sr;
  logic [7:0] m_q8;
  logic [5:0] m_q6;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .req_sr(req_sr), .req_idx(req_idx),
    .gnt(gnt), .err(err), .Q(Q), .Qbar(Qbar), .busy(busy));

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDX_W(3)) dut6 (
    .clk(clk), .reset(reset), .req(req), .req_sr(req_sr), .req_idx(req_idx),
    .gnt(gnt6), .err(err6), .Q(Q6), .Qbar(Qbar6), .busy(busy6));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_apply = 0; m_win = 0; m_ptr = 0; m_idx = 0; m_sr = 2'b00;
    m_q8 = '0; m_q6 = '0;
  endtask

  task automatic model_step();
    int j;
    if (m_apply) begin
      if (m_sr == 2'b10) begin
        m_q8[m_idx] = 1'b1;
        if (m_idx < 6) m_q6[m_idx] = 1'b1;
      end else if (m_sr == 2'b01) begin
        m_q8[m_idx] = 1'b0;
        if (m_idx < 6) m_q6[m_idx] = 1'b0;
      end
      m_ptr = (m_win + 1) % NREQ;
      m_apply = 0;
    end else if (req != 0) begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef SR_FLAG_ARB_FIXED_PRIO_EN
        j = k;
`else
        j = (m_ptr + k) % NREQ;
`endif
        if (req[j]) begin
          m_win = j; m_sr = req_sr[2*j +: 2]; m_idx = int'(req_idx[3*j +: 3]);
          m_apply = 1;
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_cmd(input int i, input logic [1:0] sr, input logic [2:0] idx);
    req_sr[2*i +: 2]  = sr;
    req_idx[3*i +: 3] = idx;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_Q got=%h exp=00", Q); end
    checks++; if (Qbar !== 8'hFF) begin errors++; $display("FAIL reset_Qbar got=%h exp=FF", Qbar); end
    checks++; if (gnt !== 4'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_outs gnt=%b err=%b busy=%b exp 0000/0/0", gnt, err, busy); end
    reset = 1'b0; model_reset();
    set_cmd(0, 2'b10, 3'd2); req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_apply gnt=%b busy=%b exp 0001/1", gnt, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (Q !== 8'h00 || gnt !== 4'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_apply_reset Q=%h gnt=%b busy=%b exp 00/0000/0", Q, gnt, busy); end
    @(posedge clk); #1;
    reset = 1'b0; req = '0; model_reset();
    tick(); tick();
    checks++; if (Q !== 8'h00 || Q6 !== 6'h00) begin
      errors++; $display("FAIL stale_write Q=%h Q6=%h exp 00/00", Q, Q6); end
  endtask

  task automatic test_single();
    set_cmd(0, 2'b10, 3'd3); req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001 || err !== 1'b0) begin
      errors++; $display("FAIL single_gnt gnt=%b err=%b exp 0001/0", gnt, err); end
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL single_Q_early got=%h exp=00", Q); end
    req = 4'b0000;
    tick();
    checks++; if (Q !== 8'h08 || gnt !== 4'b0) begin
      errors++; $display("FAIL single_set Q=%h gnt=%b exp 08/0000", Q, gnt); end
    set_cmd(0, 2'b01, 3'd3); req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt2 got=%b exp=0001", gnt); end
    req = 4'b0000;
    tick();
    checks++; if (Q !== 8'h00 || Qbar !== 8'hFF) begin
      errors++; $display("FAIL single_clear Q=%h Qbar=%h exp 00/FF", Q, Qbar); end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b10, 3'(i));
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c % 2 == 0) begin
`ifdef SR_FLAG_ARB_FIXED_PRIO_EN
        e = 0;
`else
        e = (c / 2) % 4;
`endif
        checks++; if (gnt !== 4'(1 << e) || busy !== 1'b1 || err !== 1'b0) begin
          errors++; $display("FAIL rr_grant c=%0d gnt=%b busy=%b err=%b exp gnt=%b", c, gnt, busy, err, 4'(1 << e)); end
      end else begin
        checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL rr_gap c=%0d gnt=%b busy=%b exp 0000/0", c, gnt, busy); end
      end
      if (c == 7) begin
`ifdef SR_FLAG_ARB_FIXED_PRIO_EN
        checks++; if (Q !== 8'h01) begin errors++; $display("FAIL rr_Q got=%h exp=01", Q); end
`else
        checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL rr_Q got=%h exp=0F", Q); end
`endif
      end
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_prio_0101();
    int e;
    do_reset();
    set_cmd(0, 2'b10, 3'd0); set_cmd(2, 2'b10, 3'd2);
    req = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c % 2 == 0) begin
`ifdef SR_FLAG_ARB_FIXED_PRIO_EN
        e = 0;
`else
        e = ((c / 2) % 2 == 0) ? 0 : 2;
`endif
        checks++; if (gnt !== 4'(1 << e)) begin
          errors++; $display("FAIL prio_grant c=%0d gnt=%b exp=%b", c, gnt, 4'(1 << e)); end
      end
    end
    req = 4'b0000;
    tick(); tick();
`ifdef SR_FLAG_ARB_FIXED_PRIO_EN
    checks++; if (Q !== 8'h01) begin errors++; $display("FAIL prio_Q got=%h exp=01", Q); end
`else
    checks++; if (Q !== 8'h05) begin errors++; $display("FAIL prio_Q got=%h exp=05", Q); end
`endif
  endtask

  task automatic test_illegal();
    do_reset();
    set_cmd(1, 2'b11, 3'd5); req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010 || err !== 1'b1 || err6 !== 1'b1) begin
      errors++; $display("FAIL illegal_sr gnt=%b err=%b err6=%b exp 0010/1/1", gnt, err, err6); end
    req = 4'b0000;
    tick();
    checks++; if (Q !== 8'h00 || Q6 !== 6'h00 || err !== 1'b0) begin
      errors++; $display("FAIL illegal_sr_Q Q=%h Q6=%h err=%b exp 00/00/0", Q, Q6, err); end
    set_cmd(1, 2'b10, 3'd7); req = 4'b0010;
    tick();
    checks++; if (gnt6 !== 4'b0010 || err6 !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL illegal_idx gnt6=%b err6=%b err=%b exp 0010/1/0", gnt6, err6, err); end
    req = 4'b0000;
    tick();
    checks++; if (Q6 !== 6'h00 || Q !== 8'h80) begin
      errors++; $display("FAIL illegal_idx_Q Q6=%h Q=%h exp 00/80", Q6, Q); end
  endtask

  task automatic test_hold();
    do_reset();
    set_cmd(0, 2'b10, 3'd1); req = 4'b0001;
    tick(); req = 4'b0000; tick();
    checks++; if (Q !== 8'h02) begin errors++; $display("FAIL hold_setup got=%h exp=02", Q); end
    set_cmd(2, 2'b00, 3'd1); req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100 || err !== 1'b0) begin
      errors++; $display("FAIL hold_gnt gnt=%b err=%b exp 0100/0", gnt, err); end
    req = 4'b0000;
    tick();
    checks++; if (Q !== 8'h02 || Qbar !== 8'hFD) begin
      errors++; $display("FAIL hold_Q Q=%h Qbar=%h exp 02/FD", Q, Qbar); end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    bit         e8, e6;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_apply && m_win == i) begin
          if ($urandom_range(3) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req[i] = 1'b1;
            set_cmd(i, 2'($urandom_range(3)), 3'($urandom_range(7)));
          end
        end else if ($urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
        // Scrambling commands during APPLY must not disturb the applied one.
        if (m_apply && $urandom_range(1) == 0)
          set_cmd(i, 2'($urandom_range(3)), 3'($urandom_range(7)));
      end
      tick();
      eg = m_apply ? 4'(1 << m_win) : 4'b0;
      e8 = m_apply && (m_sr == 2'b11);
      e6 = m_apply && (m_sr == 2'b11 || m_idx >= 6);
      checks++; if (gnt !== eg || gnt6 !== eg) begin
        errors++; $display("FAIL rand_gnt c=%0d gnt=%b gnt6=%b exp=%b", c, gnt, gnt6, eg); end
      checks++; if (err !== e8 || err6 !== e6) begin
        errors++; $display("FAIL rand_err c=%0d err=%b err6=%b exp %b/%b", c, err, err6, e8, e6); end
      checks++; if (busy !== m_apply || busy6 !== m_apply) begin
        errors++; $display("FAIL rand_busy c=%0d busy=%b busy6=%b exp=%b", c, busy, busy6, m_apply); end
      checks++; if (Q !== m_q8 || Q6 !== m_q6) begin
        errors++; $display("FAIL rand_Q c=%0d Q=%h Q6=%h exp %h/%h", c, Q, Q6, m_q8, m_q6); end
      checks++; if (Qbar !== ~m_q8 || Qbar6 !== ~m_q6) begin
        errors++; $display("FAIL rand_Qbar c=%0d Qbar=%h Qbar6=%h exp %h/%h", c, Qbar, Qbar6, ~m_q8, ~m_q6); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_prio_0101();
    test_illegal();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
